// File: rtl/pc_stack_counter.sv
// rtl/pc_stack_counter.sv - fetch-stage program counter with return-address stack
//
// Ports:
//   clk, rst_n   clock (rising edge) and synchronous active-low reset
//   stall        hold pc, stack and error flag this cycle
//   jmp          load pc from tgt
//   call         push pc+1 and load pc from tgt
//   ret          pop the top of stack into pc
//   tgt          jump/call target
//   pc           registered program counter
//   depth        number of valid stack entries
//   stack_empty  depth == 0
//   stack_full   depth == DEPTH
//   stack_err    sticky overflow/underflow flag, cleared only by reset
module pc_stack_counter #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       jmp,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           tgt,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       stack_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [DW-1:0]    depth_next;
  logic [DW-1:0]    depth_m1;
  logic             err_next;
  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;

  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == DW'(DEPTH));

  // Wraps modulo 2^WIDTH, so a call at all-ones pushes zero.
  assign pc_inc   = pc + WIDTH'(1);
  assign depth_m1 = depth - DW'(1);

  // Pushes only happen while depth < DEPTH and pops only while depth > 0,
  // so the low AW bits always address a valid entry.
  assign push_idx = depth[AW-1:0];
  assign pop_idx  = depth_m1[AW-1:0];

  // Fixed priority: stall > ret > call > jmp > increment.
  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    err_next   = stack_err;
    push       = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_next    = stack_mem[pop_idx];
        depth_next = depth_m1;
      end else begin
        pc_next  = pc_inc;
        err_next = 1'b1;
      end
    end else if (call) begin
      if (!stack_full) begin
        push       = 1'b1;
        pc_next    = tgt;
        depth_next = depth + DW'(1);
      end else begin
        // Overflowing call degrades to a plain increment.
        pc_next  = pc_inc;
        err_next = 1'b1;
      end
    end else if (jmp) begin
      pc_next = tgt;
    end else begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      depth     <= depth_next;
      stack_err <= err_next;
    end
  end

  // Storage needs no reset: entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_counter.sv
// tb/tb_pc_stack_counter.sv - directed self-checking bench for pc_stack_counter
module tb_pc_stack_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] tgt = '0;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_stack_counter #(
    .WIDTH(16),
    .DEPTH(8),
    .RESET_VEC(16'h0100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .jmp(jmp),
    .call(call),
    .ret(ret),
    .tgt(tgt),
    .pc(pc),
    .depth(depth),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Apply one request across one rising edge, then sample 1 time unit later.
  task automatic step(input logic s, input logic r, input logic c, input logic j,
                      input logic [15:0] t);
    stall = s; ret = r; call = c; jmp = j; tgt = t;
    @(posedge clk);
    #1;
    stall = 0; ret = 0; call = 0; jmp = 0; tgt = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(2);
    n_tests++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0100); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", depth); end
    n_tests++; if (stack_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", stack_empty); end
    n_tests++; if (stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", stack_full); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", stack_err); end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 16'h0);
      n_tests++; if (pc !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL incr_pc[%0d] got %h exp %h", i, pc, 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_call_ret;
    logic [15:0] exp_pc [4] = '{16'h2000, 16'h3000, 16'h2001, 16'h0011};
    logic [3:0]  exp_d  [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    step(0, 0, 0, 1, 16'h0010);
    n_tests++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL jmp_pc got %h exp 0010", pc); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(0, 0, 1, 0, 16'h2000);
      else if (i == 1) step(0, 0, 1, 0, 16'h3000);
      else step(0, 1, 0, 0, 16'h0);
      n_tests++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL nest_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
      n_tests++; if (depth !== exp_d[i]) begin n_fail++; $display("FAIL nest_depth[%0d] got %0d exp %0d", i, depth, exp_d[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] tg [8];
    logic [15:0] pushed [8];
    for (int i = 0; i < 7; i++) tg[i] = 16'h1000 + 16'(i * 16);
    tg[7] = 16'h4000;
    pushed[0] = 16'h0201;
    for (int i = 1; i < 8; i++) pushed[i] = tg[i-1] + 16'h1;
    step(0, 0, 0, 1, 16'h0200);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, tg[i]);
    n_tests++; if (depth !== 4'd8) begin n_fail++; $display("FAIL ovf_depth8 got %0d exp 8", depth); end
    n_tests++; if (stack_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", stack_full); end
    n_tests++; if (pc !== 16'h4000) begin n_fail++; $display("FAIL ovf_pc8 got %h exp 4000", pc); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_before got %b exp 0", stack_err); end
    step(0, 0, 1, 0, 16'h5000);
    n_tests++; if (pc !== 16'h4001) begin n_fail++; $display("FAIL ovf_pc9 got %h exp 4001", pc); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", stack_err); end
    n_tests++; if (depth !== 4'd8) begin n_fail++; $display("FAIL ovf_depth9 got %0d exp 8", depth); end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 16'h0);
      n_tests++; if (pc !== pushed[7-k]) begin n_fail++; $display("FAIL lifo_pc[%0d] got %h exp %h", k, pc, pushed[7-k]); end
      n_tests++; if (depth !== 4'(7-k)) begin n_fail++; $display("FAIL lifo_depth[%0d] got %0d exp %0d", k, depth, 7-k); end
    end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky got %b exp 1", stack_err); end
  endtask

  task automatic test_underflow_priority;
    do_reset(1);
    step(0, 0, 0, 1, 16'h0050);
    step(0, 1, 0, 0, 16'h0);
    n_tests++; if (pc !== 16'h0051) begin n_fail++; $display("FAIL udf_pc got %h exp 0051", pc); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL udf_err got %b exp 1", stack_err); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL udf_depth got %0d exp 0", depth); end
    step(0, 0, 1, 1, 16'h0700);
    n_tests++; if (pc !== 16'h0700) begin n_fail++; $display("FAIL prio_callj_pc got %h exp 0700", pc); end
    n_tests++; if (depth !== 4'd1) begin n_fail++; $display("FAIL prio_callj_depth got %0d exp 1", depth); end
    step(0, 1, 1, 1, 16'h0900);
    n_tests++; if (pc !== 16'h0052) begin n_fail++; $display("FAIL prio_ret_pc got %h exp 0052", pc); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL prio_ret_depth got %0d exp 0", depth); end
  endtask

  task automatic test_wrap_stall;
    step(0, 0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0, 16'h0);
    n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_incr got %h exp 0000", pc); end
    step(0, 0, 0, 1, 16'hFFFF);
    step(0, 0, 1, 0, 16'h0000);
    n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_call_pc got %h exp 0000", pc); end
    n_tests++; if (depth !== 4'd1) begin n_fail++; $display("FAIL wrap_call_depth got %0d exp 1", depth); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 16'h1234);
      n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 0000", i, pc); end
      n_tests++; if (depth !== 4'd1) begin n_fail++; $display("FAIL stall_depth[%0d] got %0d exp 1", i, depth); end
    end
    step(0, 1, 0, 0, 16'h0);
    n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_ret_pc got %h exp 0000", pc); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL wrap_ret_depth got %0d exp 0", depth); end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h0A00 + 16'(i));
    n_tests++; if (depth !== 4'd5) begin n_fail++; $display("FAIL mid_depth5 got %0d exp 5", depth); end
    rst_n = 1'b0;
    step(0, 0, 1, 0, 16'h0B00);
    rst_n = 1'b1;
    n_tests++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL mid_rst_pc got %h exp 0100", pc); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL mid_rst_depth got %0d exp 0", depth); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b exp 0", stack_err); end
    step(0, 0, 0, 0, 16'h0);
    n_tests++; if (pc !== 16'h0101) begin n_fail++; $display("FAIL mid_post_pc got %h exp 0101", pc); end
    step(0, 1, 0, 0, 16'h0);
    n_tests++; if (pc !== 16'h0102) begin n_fail++; $display("FAIL mid_udf_pc got %h exp 0102", pc); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL mid_udf_err got %b exp 1", stack_err); end
    n_tests++; if (stack_empty !== 1'b1) begin n_fail++; $display("FAIL mid_udf_empty got %b exp 1", stack_empty); end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow_priority();
    test_wrap_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
